// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding, timeout default, register-id width
// and the RUN-mode branch/hazard decision.
package pipeline_ctrl_pkg;

    localparam int REG_ID_W         = 4;
    localparam int WAIT_TIMEOUT_DEF = 255;
    localparam int WCNT_W           = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2,
        ST_ERR_ALT  = 2'd3
    } state_e;

    typedef struct packed {
        logic freeze_all;
        logic freeze_front;
        logic flush_if;
        logic flush_id;
    } ctrl_t;

    // A taken branch kills both young stages, so a hazard in the same cycle is moot.
    function automatic ctrl_t run_ctrl(input logic branch_taken, input logic hazard);
        ctrl_t c;
        c = '0;
        if (branch_taken) begin
            c.flush_if = 1'b1;
            c.flush_id = 1'b1;
        end else if (hazard) begin
            c.freeze_front = 1'b1;
            c.flush_id     = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_perf_cnt.sv
// Saturating stall/flush cycle counters for the pipeline controller.
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic [15:0] o_stall_cnt,
    output logic [15:0] o_flush_cnt
);
    logic [15:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
            if (i_flush && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with memory-wait timeout.
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hazard,
    input  logic        branch_taken,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic        sram_ready,
    output logic        freeze_all,
    output logic        freeze_front,
    output logic        flush_if,
    output logic        flush_id,
    output logic        mem_err,
`ifdef PIPE_PERF_CNT_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic [1:0]  state
);
    localparam logic [WCNT_W-1:0] TIMEOUT = WCNT_W'(WAIT_TIMEOUT);

    state_e             r_state, w_next;
    logic [WCNT_W-1:0]  r_wcnt, w_wcnt_nxt;
    logic               r_mem_err, w_mem_err_nxt;
    logic               w_mem_busy;
    ctrl_t              w_ctrl;

    assign w_mem_busy = (mem_r_en | mem_w_en) & ~sram_ready;

    always_comb begin
        w_next        = r_state;
        w_wcnt_nxt    = r_wcnt;
        w_mem_err_nxt = r_mem_err;
        w_ctrl        = '0;
        case (r_state)
            ST_RUN: begin
                if (w_mem_busy) begin
                    w_ctrl.freeze_all = 1'b1;
                    w_next            = ST_MEM_WAIT;
                    w_wcnt_nxt        = 8'd1;
                end else begin
                    w_ctrl = run_ctrl(branch_taken, hazard);
                end
            end
            ST_MEM_WAIT: begin
                if (!sram_ready) begin
                    w_ctrl.freeze_all = 1'b1;
                    if (r_wcnt == TIMEOUT) begin
                        w_next        = ST_ERR;
                        w_mem_err_nxt = 1'b1;
                    end else if (r_wcnt != 8'hFF) begin
                        w_wcnt_nxt = r_wcnt + 8'd1;
                    end
                end else begin
                    // Access completes: whatever branch/hazard was held behind it acts now.
                    w_ctrl     = run_ctrl(branch_taken, hazard);
                    w_next     = ST_RUN;
                    w_wcnt_nxt = '0;
                end
            end
            default: begin
                w_ctrl.freeze_all = 1'b1;
                w_next            = ST_ERR;
                w_mem_err_nxt     = 1'b1;
            end
        endcase
        if (!rst_n) begin
            w_ctrl          = '0;
            w_ctrl.flush_if = 1'b1;
            w_ctrl.flush_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_wcnt    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wcnt    <= w_wcnt_nxt;
            r_mem_err <= w_mem_err_nxt;
        end
    end

    assign freeze_all   = w_ctrl.freeze_all;
    assign freeze_front = w_ctrl.freeze_front;
    assign flush_if     = w_ctrl.flush_if;
    assign flush_id     = w_ctrl.flush_id;
    assign mem_err      = r_mem_err;
    assign state        = r_state;

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_cnt u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stall     (w_ctrl.freeze_all | w_ctrl.freeze_front),
        .i_flush     (w_ctrl.flush_if),
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt)
    );
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random traffic
// compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n, hazard, branch_taken, mem_r_en, mem_w_en, sram_ready;
    logic freeze_all, freeze_front, flush_if, flush_id, mem_err;
    logic [1:0] state;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    pipeline_ctrl #(.WAIT_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .sram_ready   (sram_ready),
        .freeze_all   (freeze_all),
        .freeze_front (freeze_front),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .mem_err      (mem_err),
`ifdef PIPE_PERF_CNT_EN
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .state        (state)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntotal = 0;

    // Model: waiting on memory for m_waited cycles, or stuck in error.
    bit m_wait, m_err;
    int m_waited;
    int m_stall, m_flush;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        ntotal++;
        assert (got === exp) begin
            npass++;
        end else begin
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit rst, input bit hz, input bit br,
                        input bit re, input bit we, input bit rdy);
        bit e_fa, e_ff, e_fi, e_fd;
        bit n_wait, n_err;
        int n_waited;
        @(negedge clk);
        rst_n = rst; hazard = hz; branch_taken = br;
        mem_r_en = re; mem_w_en = we; sram_ready = rdy;
        #1;
        e_fa = 0; e_ff = 0; e_fi = 0; e_fd = 0;
        n_wait = m_wait; n_err = m_err; n_waited = m_waited;
        if (!rst) begin
            e_fi = 1; e_fd = 1;
            n_wait = 0; n_err = 0; n_waited = 0;
        end else if (m_err) begin
            e_fa = 1;
        end else if (m_wait && !rdy) begin
            e_fa = 1;
            if (m_waited == TO) begin
                n_err = 1; n_wait = 0;
            end else begin
                n_waited = m_waited + 1;
            end
        end else if (!m_wait && (re || we) && !rdy) begin
            e_fa = 1; n_wait = 1; n_waited = 1;
        end else begin
            if (br) begin
                e_fi = 1; e_fd = 1;
            end else if (hz) begin
                e_ff = 1; e_fd = 1;
            end
            n_wait = 0; n_waited = 0;
        end
        chk("freeze_all",   16'(freeze_all),   16'(e_fa));
        chk("freeze_front", 16'(freeze_front), 16'(e_ff));
        chk("flush_if",     16'(flush_if),     16'(e_fi));
        chk("flush_id",     16'(flush_id),     16'(e_fd));
        chk("state",        16'(state),        m_err ? 16'd2 : (m_wait ? 16'd1 : 16'd0));
        chk("mem_err",      16'(mem_err),      16'(m_err));
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, 16'(m_stall));
        chk("flush_cnt", flush_cnt, 16'(m_flush));
`endif
        @(posedge clk);
        m_wait = n_wait; m_err = n_err; m_waited = n_waited;
        if (!rst) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if ((e_fa || e_ff) && m_stall < 16'hFFFF) m_stall++;
            if (e_fi && m_flush < 16'hFFFF) m_flush++;
        end
    endtask

    initial begin
        rst_n = 0; hazard = 0; branch_taken = 0;
        mem_r_en = 0; mem_w_en = 0; sram_ready = 0;
        repeat (2) @(posedge clk);
        m_wait = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;

        // Reset state and forced flush outputs
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // Hazard alone, then hazard with branch
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0);
        // Access completing the same cycle is not a stall
        step(1, 0, 0, 1, 0, 1);
        // Three-cycle read wait, branch in the ready cycle
        step(1, 0, 0, 1, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        // Wait, then hazard acted on in the ready cycle
        step(1, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 1);
        // Write timeout into error; error is sticky against any input
        repeat (TO + 1) step(1, 0, 0, 0, 1, 0);
        step(1, 1, 1, 0, 0, 1);
        step(1, 0, 0, 1, 1, 1);
        step(1, 1, 0, 0, 0, 0);
        // Reset leaves error state
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        // Reset in the middle of a memory wait
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 29) != 0, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 0);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: WAIT_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before the error state (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 hazard  input  1  RAW hazard flag from the hazard detection unit (ID vs EXE/MEM dest).
REQ-005 branch_taken  input  1  branch resolved taken in EXE.
REQ-006 mem_r_en, mem_w_en  input  1 each  MEM stage memory access request.
REQ-007 sram_ready  input  1  memory completes the current access this cycle.
REQ-008 freeze_all  output  1  hold every pipeline register (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB).
REQ-009 freeze_front  output  1  hold PC and IF/ID only.
REQ-010 flush_if  output  1  clear IF/ID (kill fetched instruction).
REQ-011 flush_id  output  1  clear ID/EXE (insert bubble).
REQ-012 mem_err  output  1  sticky memory timeout error.
REQ-013 state  output  2  current FSM state encoding.

Function
REQ-014 FSM states SHALL be RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2; 2'd3 SHALL behave as ERR.
REQ-015 Outputs freeze_all, freeze_front, flush_if, flush_id SHALL be combinational (Mealy) from state and inputs; zero added latency.
REQ-016 Let mem_busy = (mem_r_en | mem_w_en) & ~sram_ready.
REQ-017 In RUN, priority SHALL be mem_busy > branch_taken > hazard, evaluated each cycle.
REQ-018 RUN, mem_busy: freeze_all=1, all other control outputs 0, next state MEM_WAIT, wait counter loaded with 1.
REQ-019 RUN, ~mem_busy & branch_taken: flush_if=1, flush_id=1, freezes 0, stay RUN; hazard ignored that cycle.
REQ-020 RUN, ~mem_busy & ~branch_taken & hazard: freeze_front=1, flush_id=1, stay RUN.
REQ-021 RUN, none of the above: all control outputs 0.
REQ-022 MEM_WAIT: freeze_all=1 while ~sram_ready; branch_taken and hazard ignored; counter increments by 1 per cycle.
REQ-023 MEM_WAIT, sram_ready=1: outputs evaluated as in RUN with mem_busy treated as 0 (pending branch/hazard acted on that cycle); next state RUN; counter cleared.
REQ-024 MEM_WAIT, ~sram_ready and counter == WAIT_TIMEOUT: next state ERR, mem_err set.
REQ-025 ERR: freeze_all=1, other controls 0, mem_err=1; exit only by reset.
REQ-026 Counter SHALL be 8 bits, never wraps (saturates at 255).
REQ-027 freeze_all and freeze_front SHALL never both be 1; freeze_all=1 implies flush_if=flush_id=0.

Reset
REQ-028 While rst_n=0 at a clock edge: state<=RUN, counter<=0, mem_err<=0.
REQ-029 While rst_n=0, combinational outputs SHALL be forced: flush_if=1, flush_id=1, freeze_all=0, freeze_front=0.
REQ-030 Reset asserted mid-MEM_WAIT or in ERR SHALL return to RUN on the next edge with no residual stall.

Configuration
REQ-031 Macro PIPE_PERF_CNT_EN: when defined, add outputs stall_cnt[15:0] (cycles with freeze_all or freeze_front =1) and flush_cnt[15:0] (cycles with flush_if=1), both saturating at 16'hFFFF, cleared by reset.
REQ-032 Without PIPE_PERF_CNT_EN these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 State encodings and WAIT_TIMEOUT default SHALL live in the shared pipeline package alongside the register-id width (4).
REQ-034 Single module, no sub-modules; optional counters may be one sub-module pipe_perf_cnt.

Verification
REQ-035 RUN, hazard=1 alone -> freeze_front=1, flush_id=1, flush_if=0, freeze_all=0, state stays 0.
REQ-036 hazard=1 and branch_taken=1 same cycle -> flush_if=1, flush_id=1, freeze_front=0.
REQ-037 mem_r_en=1, sram_ready=0 for 3 cycles then 1 -> freeze_all=1 for 3 cycles, state 1, then state 0; branch_taken=1 in the ready cycle -> flush_if=1 that cycle.
REQ-038 WAIT_TIMEOUT=4, mem_w_en=1, sram_ready held 0 -> state 2 and mem_err=1 after the counter reaches 4; stays until rst_n=0.
REQ-039 rst_n=0 during MEM_WAIT -> outputs flush_if=flush_id=1 immediately, state 0 after edge, mem_err 0.
REQ-040 With PIPE_PERF_CNT_EN, 5 hazard cycles and 2 branch cycles -> stall_cnt=5, flush_cnt=2.
